// File: rtl/cdc_pkg.sv
// Shared types and default sizing for the register-access clock-domain crossing.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    WAIT_RD = 2'd2,
    ACK     = 2'd3
  } state_e;

  localparam int unsigned DEF_AW          = 6;
  localparam int unsigned DEF_DW          = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_RD_LATENCY  = 1;
  localparam int unsigned DEF_CNT_W       = 16;

endpackage

// File: rtl/cdc_sync_bit.sv
// N-stage single-bit synchroniser for a level or toggle arriving from another clock domain.
module cdc_sync_bit #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/cdc_hs_rx.sv
// Destination side of the toggle request/acknowledge crossing: captures the source-held
// bundle, issues one register-file strobe and returns read data with an ack toggle.
module cdc_hs_rx
  import cdc_pkg::*;
#(
  parameter int unsigned AW          = DEF_AW,
  parameter int unsigned DW          = DEF_DW,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned RD_LATENCY  = DEF_RD_LATENCY,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_tgl,
  input  logic [AW-1:0]    p_address,
  input  logic [DW-1:0]    p_data,
  input  logic             p_wr,
  output logic             ack_tgl,
  output logic [DW-1:0]    p_data_back,
  output logic [AW-1:0]    CDC_A,
  output logic [DW-1:0]    CDC_data,
  output logic             CDC_wr,
  output logic             CDC_rd,
  input  logic [DW-1:0]    data_back,
  output logic             busy,
  output logic             proto_err,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int unsigned RW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [RW-1:0] RD_LAST = RW'(RD_LATENCY - 1);

  state_e           state_q, state_d;
  logic             req_s;
  logic             req_seen_q, req_seen_d;
  logic             req_pend_q, req_pend_d;
  logic             wr_lat_q, wr_lat_d;
  logic             ack_q, ack_d;
  logic [AW-1:0]    cdc_a_q, cdc_a_d;
  logic [DW-1:0]    cdc_data_q, cdc_data_d;
  logic             cdc_wr_q, cdc_wr_d;
  logic             cdc_rd_q, cdc_rd_d;
  logic [DW-1:0]    pdb_q, pdb_d;
  logic             proto_err_q, proto_err_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [RW-1:0]    rd_cnt_q, rd_cnt_d;

  cdc_sync_bit #(.N(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d_i (req_tgl),
    .q_o (req_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_seen_q  <= 1'b0;
      req_pend_q  <= 1'b0;
      wr_lat_q    <= 1'b0;
      ack_q       <= 1'b0;
      cdc_a_q     <= '0;
      cdc_data_q  <= '0;
      cdc_wr_q    <= 1'b0;
      cdc_rd_q    <= 1'b0;
      pdb_q       <= '0;
      proto_err_q <= 1'b0;
      xfer_cnt_q  <= '0;
      rd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_seen_q  <= req_seen_d;
      req_pend_q  <= req_pend_d;
      wr_lat_q    <= wr_lat_d;
      ack_q       <= ack_d;
      cdc_a_q     <= cdc_a_d;
      cdc_data_q  <= cdc_data_d;
      cdc_wr_q    <= cdc_wr_d;
      cdc_rd_q    <= cdc_rd_d;
      pdb_q       <= pdb_d;
      proto_err_q <= proto_err_d;
      xfer_cnt_q  <= xfer_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_seen_d  = req_seen_q;
    req_pend_d  = req_pend_q;
    wr_lat_d    = wr_lat_q;
    ack_d       = ack_q;
    cdc_a_d     = cdc_a_q;
    cdc_data_d  = cdc_data_q;
    cdc_wr_d    = 1'b0;
    cdc_rd_d    = 1'b0;
    pdb_d       = pdb_q;
    xfer_cnt_d  = xfer_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    // Source moved its toggle again before we acknowledged the pending one.
    proto_err_d = proto_err_q | ((state_q != IDLE) && (req_s != req_pend_q));

    case (state_q)
      IDLE: begin
        if (req_s != req_seen_q) begin
          cdc_a_d    = p_address;
          cdc_data_d = p_data;
          wr_lat_d   = p_wr;
          req_pend_d = req_s;
          cdc_wr_d   = p_wr;
          cdc_rd_d   = ~p_wr;
          state_d    = CAPTURE;
        end
      end
      CAPTURE: begin
        rd_cnt_d = '0;
        state_d  = wr_lat_q ? ACK : WAIT_RD;
      end
      WAIT_RD: begin
        if (rd_cnt_q == RD_LAST) begin
          pdb_d   = data_back;
          state_d = ACK;
        end else begin
          rd_cnt_d = rd_cnt_q + RW'(1);
        end
      end
      ACK: begin
        ack_d      = ~ack_q;
        req_seen_d = req_pend_q;
        xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ack_tgl     = ack_q;
  assign p_data_back = pdb_q;
  assign CDC_A       = cdc_a_q;
  assign CDC_data    = cdc_data_q;
  assign CDC_wr      = cdc_wr_q;
  assign CDC_rd      = cdc_rd_q;
  assign proto_err   = proto_err_q;
  assign xfer_cnt    = xfer_cnt_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/cdc_hs_rx.md
Name: cdc_hs_rx

Overview:
Destination-side half of the next-generation register-access crossing. It replaces free-running bus synchronisation with a toggle request/acknowledge handshake, so a multi-bit address/data word crosses coherently. The block runs entirely in the destination clock. It synchronises only the request toggle, then captures the source-held bundle and issues a one-cycle write or read strobe to the register file. Read data is held stable for the source before acknowledging. Widths, synchroniser depth and read latency are parametrised.

Parameters:
AW, 6, address width
DW, 16, data width
SYNC_STAGES, 2, flops in request synchroniser (legal ≥2)
RD_LATENCY, 1, cycles from read strobe to valid data_back (legal ≥1)
CNT_W, 16, width of transfer counter

Ports:
clk  in  1  destination clock
rst  in  1  asynchronous active-high reset
req_tgl  in  1  source request toggle (asynchronous to clk)
p_address  in  AW  source address, held stable from req toggle until ack toggle
p_data  in  DW  source write data, same stability rule
p_wr  in  1  1 = write, 0 = read, same stability rule
ack_tgl  out  1  acknowledge toggle back to source
p_data_back  out  DW  read data held for source, stable when ack toggles
CDC_A  out  AW  register-file address
CDC_data  out  DW  register-file write data
CDC_wr  out  1  one-cycle write strobe
CDC_rd  out  1  one-cycle read strobe
data_back  in  DW  register-file read data
busy  out  1  FSM not IDLE
proto_err  out  1  sticky protocol-violation flag
xfer_cnt  out  CNT_W  completed-transfer count

Behaviour:
- Reset: the clock and reset are fixed: one clock clk; reset rst is asynchronous and active-high. While rst=1 all flops clear: sync chain, req_seen, ack_tgl, CDC_A, CDC_data, CDC_wr, CDC_rd, p_data_back, proto_err and xfer_cnt all go to 0, and the FSM goes to IDLE. No other input is sampled asynchronously.
- Synchroniser: req_tgl → SYNC_STAGES flops → req_s. Only req_tgl is synchronised. Bundle inputs are sampled only in the capture transition.
- FSM states: IDLE, CAPTURE, WAIT_RD, ACK.
- IDLE: when req_s != req_seen, on that edge latch p_address→CDC_A, p_data→CDC_data, p_wr→wr_lat, req_s→req_pend, and go to CAPTURE.
- CAPTURE (exactly 1 cycle): CDC_wr = wr_lat and CDC_rd = !wr_lat, both registered high only in this cycle. Next state is ACK if write, WAIT_RD if read.
- WAIT_RD: stay RD_LATENCY cycles. On the edge leaving it, data_back→p_data_back, then go to ACK.
- ACK (1 cycle): on the edge leaving it, ack_tgl inverts, req_seen←req_pend, xfer_cnt increments (wraps at 2^CNT_W), then go to IDLE.
- CDC_A and CDC_data hold their value until the next capture. p_data_back changes only on a read completion; writes leave it untouched.
- Latency, with the toggle first sampled at edge k and S = SYNC_STAGES:
  - CAPTURE entered at edge k+S.
  - Write: ack toggles at edge k+S+2.
  - Read: ack toggles at edge k+S+2+RD_LATENCY.
  - p_data_back is valid one edge before the ack toggle.
- Back-to-back: a new toggle seen while the FSM is in IDLE immediately after ACK starts the next transfer with no dead cycle beyond IDLE.
- Protocol violation: if req_s != req_pend in any cycle while state ≠ IDLE, proto_err ← 1. It is sticky until rst. The current transfer still completes normally.
- Reset mid-transfer: the transfer is abandoned with no strobe and no ack toggle, and req_seen returns to 0. If req_tgl=1 at reset release, that is detected as a new request after S cycles. The source must be reset together with this block.
- busy = (state != IDLE), driven combinationally from the state register.

Decomposition:
- Package cdc_pkg: FSM state enum (IDLE, CAPTURE, WAIT_RD, ACK) and default parameter constants.
- Sub-module cdc_sync_bit: parametrised N-stage single-bit synchroniser, instantiated once for req_tgl. It is reused later by the source-side block for ack_tgl.

Test Plan:
1. Reset values: rst=1 while req_tgl=0 → all outputs 0, busy=0; release and hold 10 cycles → no strobes.
2. Write: p_address=6'h0A, p_data=16'hBEEF, p_wr=1, toggle req_tgl 0→1 → CDC_wr pulses exactly 1 cycle at edge k+2 with CDC_A=0A, CDC_data=BEEF; ack_tgl=1 at k+4; xfer_cnt=1; p_data_back unchanged.
3. Read: p_address=6'h03, p_wr=0, data_back=16'h1234, toggle req_tgl → CDC_rd one-cycle pulse, p_data_back=1234 one edge before ack_tgl toggles at k+5; CDC_wr never asserts.
4. Back-to-back: 3 transfers (write, read, write), each issued when the source sees ack change → 3 strobes in order, ack_tgl toggles 3 times, xfer_cnt=3, proto_err=0.
5. Violation: toggle req_tgl twice 1 cycle apart → one transfer executes, proto_err=1 and stays 1 until rst.
6. Reset mid-read with RD_LATENCY=4: assert rst during WAIT_RD → no ack toggle, p_data_back=0, busy=0; after release with req_tgl=1, a new transfer starts after 2 cycles.
